// File: rtl/except_commit_handler_pkg.sv
// Shared exception types, CSR addresses and the status-word rewrite helpers
// used when committing a trap or an xRET.
package ExceptStruct;

    typedef struct packed {
        logic        except;
        logic [63:0] epc;
        logic [63:0] ecause;
        logic [63:0] etval;
    } ExceptPack;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_STVAL   = 12'h143;

    // Trap entry: stash the interrupt enable into xPIE, clear xIE and record the old privilege.
    function automatic logic [63:0] trap_status(input logic [63:0] ms, input logic [1:0] p,
                                                input logic to_s);
        logic [63:0] s;
        s = ms;
        if (to_s) begin
            s[5]     = ms[1];
            s[1]     = 1'b0;
            s[8]     = p[0];
        end else begin
            s[7]     = ms[3];
            s[3]     = 1'b0;
            s[12:11] = p;
        end
        return s;
    endfunction

    function automatic logic [63:0] mret_status(input logic [63:0] ms);
        logic [63:0] s;
        s        = ms;
        s[3]     = ms[7];
        s[7]     = 1'b1;
        s[12:11] = 2'b00;
        return s;
    endfunction

    function automatic logic [63:0] sret_status(input logic [63:0] ms);
        logic [63:0] s;
        s    = ms;
        s[1] = ms[5];
        s[5] = 1'b1;
        s[8] = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/except_commit_handler_trap_target_sel.sv
// Decides whether a trap is delegated to S-mode and returns the matching
// trap vector with its mode bits cleared.
module trap_target_sel
    import ExceptStruct::*;
#(
    parameter bit SUPPORT_S = 1'b1
) (
    input  logic [1:0]  priv,
    input  logic        ecause_int,
    input  logic [5:0]  ecause_code,
    input  logic [63:0] medeleg,
    input  logic [63:0] mtvec,
    input  logic [63:0] stvec,
    output logic        to_s,
    output logic [63:0] tvec_pc
);

    always_comb begin
        to_s    = SUPPORT_S && (priv != 2'd3) && !ecause_int && medeleg[ecause_code];
        tvec_pc = (to_s ? stvec : mtvec) & ~64'h3;
    end

endmodule

// File: rtl/except_commit_handler.sv
// Serialises trap and xRET commits into one CSR write per cycle, followed by a
// single-cycle fetch redirect, flush and privilege update.
module except_commit_handler
    import ExceptStruct::*;
#(
    parameter bit SUPPORT_S = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  ExceptPack   except_wb,
    input  logic        valid_wb,
    input  logic        mret_wb,
    input  logic        sret_wb,
    input  logic [1:0]  priv,
    input  logic [63:0] mstatus,
    input  logic [63:0] medeleg,
    input  logic [63:0] mtvec,
    input  logic [63:0] stvec,
    input  logic [63:0] mepc,
    input  logic [63:0] sepc,
    output logic        csr_we,
    output logic [11:0] csr_waddr,
    output logic [63:0] csr_wdata,
    output logic        priv_we,
    output logic [1:0]  priv_next,
    output logic        redirect,
    output logic [63:0] redirect_pc,
    output logic        stall_all,
    output logic        flush_all,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_W_EPC, S_W_CAUSE, S_W_TVAL, S_W_STATUS, S_RET_STATUS, S_REDIRECT
    } state_e;

    typedef enum logic [1:0] {K_TRAP, K_MRET, K_SRET} kind_e;

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    ExceptPack   pack_q, pack_d;
    logic [63:0] mstatus_q, mstatus_d;
    logic [1:0]  priv_q, priv_d;
    logic        to_s_q, to_s_d;
    logic [63:0] target_pc_q, target_pc_d;

    logic        csr_we_q, csr_we_d;
    logic [11:0] csr_waddr_q, csr_waddr_d;
    logic [63:0] csr_wdata_q, csr_wdata_d;
    logic        priv_we_q, priv_we_d;
    logic [1:0]  priv_next_q, priv_next_d;
    logic        redirect_q, redirect_d;
    logic [63:0] redirect_pc_q, redirect_pc_d;
    logic        flush_q, flush_d;

    logic        sel_to_s;
    logic [63:0] sel_tvec_pc;
    logic        idle, accept_trap, accept_ret;

    trap_target_sel #(.SUPPORT_S(SUPPORT_S)) u_trap_target_sel (
        .priv        (priv),
        .ecause_int  (except_wb.ecause[63]),
        .ecause_code (except_wb.ecause[5:0]),
        .medeleg     (medeleg),
        .mtvec       (mtvec),
        .stvec       (stvec),
        .to_s        (sel_to_s),
        .tvec_pc     (sel_tvec_pc)
    );

    always_comb begin
        idle        = (state_q == S_IDLE);
        accept_trap = idle && valid_wb && except_wb.except;
        accept_ret  = idle && valid_wb && !except_wb.except && (mret_wb || sret_wb);
    end

    // Everything needed after accept is captured here; inputs are ignored until IDLE again.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        pack_d      = pack_q;
        mstatus_d   = mstatus_q;
        priv_d      = priv_q;
        to_s_d      = to_s_q;
        target_pc_d = target_pc_q;
        case (state_q)
            S_IDLE: begin
                if (accept_trap) begin
                    state_d     = S_W_EPC;
                    kind_d      = K_TRAP;
                    pack_d      = except_wb;
                    mstatus_d   = mstatus;
                    priv_d      = priv;
                    to_s_d      = sel_to_s;
                    target_pc_d = sel_tvec_pc;
                end else if (accept_ret) begin
                    state_d     = S_RET_STATUS;
                    kind_d      = mret_wb ? K_MRET : K_SRET;
                    pack_d      = except_wb;
                    mstatus_d   = mstatus;
                    priv_d      = priv;
                    to_s_d      = !mret_wb;
                    target_pc_d = mret_wb ? mepc : sepc;
                end
            end
            S_W_EPC:      state_d = S_W_CAUSE;
            S_W_CAUSE:    state_d = S_W_TVAL;
            S_W_TVAL:     state_d = S_W_STATUS;
            S_W_STATUS:   state_d = S_REDIRECT;
            S_RET_STATUS: state_d = S_REDIRECT;
            default:      state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in that state.
    always_comb begin
        csr_we_d      = 1'b0;
        csr_waddr_d   = '0;
        csr_wdata_d   = '0;
        priv_we_d     = 1'b0;
        priv_next_d   = '0;
        redirect_d    = 1'b0;
        redirect_pc_d = '0;
        flush_d       = 1'b0;
        case (state_d)
            S_W_EPC: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = to_s_d ? CSR_SEPC : CSR_MEPC;
                csr_wdata_d = pack_d.epc;
            end
            S_W_CAUSE: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = to_s_d ? CSR_SCAUSE : CSR_MCAUSE;
                csr_wdata_d = pack_d.ecause;
            end
            S_W_TVAL: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = to_s_d ? CSR_STVAL : CSR_MTVAL;
                csr_wdata_d = pack_d.etval;
            end
            S_W_STATUS: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_MSTATUS;
                csr_wdata_d = trap_status(mstatus_d, priv_d, to_s_d);
            end
            S_RET_STATUS: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_MSTATUS;
                csr_wdata_d = (kind_d == K_MRET) ? mret_status(mstatus_d) : sret_status(mstatus_d);
            end
            S_REDIRECT: begin
                redirect_d    = 1'b1;
                redirect_pc_d = target_pc_d;
                priv_we_d     = 1'b1;
                flush_d       = 1'b1;
                case (kind_d)
                    K_TRAP:  priv_next_d = to_s_d ? 2'd1 : 2'd3;
                    K_MRET:  priv_next_d = mstatus_d[12:11];
                    default: priv_next_d = {1'b0, mstatus_d[8]};
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            kind_q        <= K_TRAP;
            pack_q        <= '0;
            mstatus_q     <= '0;
            priv_q        <= '0;
            to_s_q        <= 1'b0;
            target_pc_q   <= '0;
            csr_we_q      <= 1'b0;
            csr_waddr_q   <= '0;
            csr_wdata_q   <= '0;
            priv_we_q     <= 1'b0;
            priv_next_q   <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            pack_q        <= pack_d;
            mstatus_q     <= mstatus_d;
            priv_q        <= priv_d;
            to_s_q        <= to_s_d;
            target_pc_q   <= target_pc_d;
            csr_we_q      <= csr_we_d;
            csr_waddr_q   <= csr_waddr_d;
            csr_wdata_q   <= csr_wdata_d;
            priv_we_q     <= priv_we_d;
            priv_next_q   <= priv_next_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            flush_q       <= flush_d;
        end
    end

    // The accept-cycle stall depends on live inputs, so it is gated by reset explicitly.
    always_comb begin
        csr_we      = csr_we_q;
        csr_waddr   = csr_waddr_q;
        csr_wdata   = csr_wdata_q;
        priv_we     = priv_we_q;
        priv_next   = priv_next_q;
        redirect    = redirect_q;
        redirect_pc = redirect_pc_q;
        flush_all   = flush_q;
        busy        = !idle;
        stall_all   = rst && ((accept_trap || accept_ret) ||
                              (!idle && (state_q != S_REDIRECT)));
    end

endmodule

// File: tb/tb_except_commit_handler.sv
// Bench for except_commit_handler: directed and randomized trap/xRET commits
// compared cycle by cycle against a behavioural model of the commit sequence.
module tb_except_commit_handler;
    import ExceptStruct::*;

    localparam bit SUPPORT_S = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    ExceptPack   except_wb;
    logic        valid_wb, mret_wb, sret_wb;
    logic [1:0]  priv;
    logic [63:0] mstatus, medeleg, mtvec, stvec, mepc, sepc;
    logic        csr_we, priv_we, redirect, stall_all, flush_all, busy;
    logic [11:0] csr_waddr;
    logic [63:0] csr_wdata, redirect_pc;
    logic [1:0]  priv_next;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [63:0] data;
        logic        redir;
        logic [63:0] pc;
        logic        pwe;
        logic [1:0]  pnext;
        logic        flush;
        logic        stall;
        logic        busy;
    } obs_t;

    obs_t exp_q[$];

    except_commit_handler #(.SUPPORT_S(SUPPORT_S)) dut (
        .clk         (clk),
        .rst         (rst),
        .except_wb   (except_wb),
        .valid_wb    (valid_wb),
        .mret_wb     (mret_wb),
        .sret_wb     (sret_wb),
        .priv        (priv),
        .mstatus     (mstatus),
        .medeleg     (medeleg),
        .mtvec       (mtvec),
        .stvec       (stvec),
        .mepc        (mepc),
        .sepc        (sepc),
        .csr_we      (csr_we),
        .csr_waddr   (csr_waddr),
        .csr_wdata   (csr_wdata),
        .priv_we     (priv_we),
        .priv_next   (priv_next),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall_all   (stall_all),
        .flush_all   (flush_all),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample_obs();
        obs_t o;
        o.we    = csr_we;
        o.addr  = csr_waddr;
        o.data  = csr_wdata;
        o.redir = redirect;
        o.pc    = redirect_pc;
        o.pwe   = priv_we;
        o.pnext = priv_next;
        o.flush = flush_all;
        o.stall = stall_all;
        o.busy  = busy;
        return o;
    endfunction

    task automatic check_obs(input string tag, input obs_t exp);
        obs_t got;
        got = sample_obs();
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got we=%b addr=%h data=%h redir=%b pc=%h pwe=%b pnext=%0d flush=%b stall=%b busy=%b | exp we=%b addr=%h data=%h redir=%b pc=%h pwe=%b pnext=%0d flush=%b stall=%b busy=%b",
                   tag, got.we, got.addr, got.data, got.redir, got.pc, got.pwe, got.pnext,
                   got.flush, got.stall, got.busy, exp.we, exp.addr, exp.data, exp.redir,
                   exp.pc, exp.pwe, exp.pnext, exp.flush, exp.stall, exp.busy);
        end
    endtask

    task automatic clear_inputs();
        except_wb = '0;
        valid_wb  = 1'b0;
        mret_wb   = 1'b0;
        sret_wb   = 1'b0;
        priv      = 2'd0;
        mstatus   = '0;
        medeleg   = '0;
        mtvec     = '0;
        stvec     = '0;
        mepc      = '0;
        sepc      = '0;
    endtask

    function automatic obs_t csr_step(input logic [11:0] a, input logic [63:0] d);
        obs_t e;
        e       = '0;
        e.we    = 1'b1;
        e.addr  = a;
        e.data  = d;
        e.stall = 1'b1;
        e.busy  = 1'b1;
        return e;
    endfunction

    function automatic obs_t redir_step(input logic [63:0] pc, input logic [1:0] pn);
        obs_t e;
        e       = '0;
        e.redir = 1'b1;
        e.pc    = pc;
        e.pwe   = 1'b1;
        e.pnext = pn;
        e.flush = 1'b1;
        e.busy  = 1'b1;
        return e;
    endfunction

    // Reference: the architectural effect of a commit, expressed as the list of
    // per-cycle outputs that follow the accept cycle.
    task automatic model_txn();
        logic        to_s;
        logic [11:0] base;
        logic [63:0] st;
        exp_q.delete();
        if (except_wb.except) begin
            to_s = SUPPORT_S && (priv != 2'd3) && !except_wb.ecause[63] &&
                   medeleg[except_wb.ecause[5:0]];
            base = to_s ? 12'h100 : 12'h300;
            if (to_s)
                st = (mstatus & ~64'h122) | ({63'b0, mstatus[1]} << 5) | ({63'b0, priv[0]} << 8);
            else
                st = (mstatus & ~64'h1888) | ({63'b0, mstatus[3]} << 7) | ({62'b0, priv} << 11);
            exp_q.push_back(csr_step(base + 12'h41, except_wb.epc));
            exp_q.push_back(csr_step(base + 12'h42, except_wb.ecause));
            exp_q.push_back(csr_step(base + 12'h43, except_wb.etval));
            exp_q.push_back(csr_step(12'h300, st));
            exp_q.push_back(redir_step(((to_s ? stvec : mtvec) >> 2) << 2, to_s ? 2'd1 : 2'd3));
        end else if (mret_wb) begin
            st = (mstatus & ~64'h1888) | ({63'b0, mstatus[7]} << 3) | 64'h80;
            exp_q.push_back(csr_step(12'h300, st));
            exp_q.push_back(redir_step(mepc, mstatus[12:11]));
        end else begin
            st = (mstatus & ~64'h122) | ({63'b0, mstatus[5]} << 1) | 64'h20;
            exp_q.push_back(csr_step(12'h300, st));
            exp_q.push_back(redir_step(sepc, {1'b0, mstatus[8]}));
        end
    endtask

    task automatic noise_inputs();
        except_wb.except = 1'($urandom_range(0, 1));
        except_wb.epc    = {$urandom, $urandom};
        except_wb.ecause = {$urandom, $urandom};
        except_wb.etval  = {$urandom, $urandom};
        valid_wb         = 1'($urandom_range(0, 1));
        mret_wb          = 1'($urandom_range(0, 1));
        sret_wb          = 1'($urandom_range(0, 1));
        priv             = 2'($urandom_range(0, 3));
        mstatus          = {$urandom, $urandom};
        medeleg          = {$urandom, $urandom};
    endtask

    // Caller has driven a committing instruction just after a rising edge.
    task automatic do_txn(input string tag, input bit noise);
        obs_t e;
        model_txn();
        @(negedge clk);
        e       = '0;
        e.stall = 1'b1;
        check_obs({tag, "_accept"}, e);
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            if (noise) noise_inputs();
            else valid_wb = 1'b0;
            @(negedge clk);
            e = exp_q.pop_front();
            check_obs(tag, e);
        end
        @(posedge clk);
        #1;
        valid_wb = 1'b0;
        @(negedge clk);
        check_obs({tag, "_idle"}, '0);
    endtask

    task automatic start_cycle();
        @(posedge clk);
        #1;
        clear_inputs();
        valid_wb = 1'b1;
    endtask

    initial begin
        int p;
        rst = 1'b0;
        clear_inputs();
        valid_wb         = 1'b1;
        except_wb.except = 1'b1;
        #2;
        check_obs("reset_outputs", '0);
        repeat (3) @(posedge clk);
        #1;
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        check_obs("post_reset_idle", '0);

        // Exception without valid_wb must not start anything.
        @(posedge clk);
        #1;
        except_wb.except = 1'b1;
        @(negedge clk);
        check_obs("invalid_no_accept", '0);
        @(posedge clk);
        #1;
        except_wb.except = 1'b0;
        @(negedge clk);
        check_obs("invalid_no_busy", '0);

        start_cycle();
        except_wb = '{except: 1'b1, epc: 64'h8000_0010, ecause: 64'd2, etval: 64'hDEAD};
        mtvec     = 64'h8000_0101;
        mstatus   = 64'h8;
        do_txn("m_trap", 1'b0);

        start_cycle();
        except_wb = '{except: 1'b1, epc: 64'h2000, ecause: 64'd8, etval: 64'h77};
        medeleg   = 64'h100;
        stvec     = 64'h4000;
        mtvec     = 64'h9000;
        mstatus   = 64'h2;
        do_txn("s_deleg_trap", 1'b0);

        start_cycle();
        except_wb = '{except: 1'b1, epc: 64'h3000, ecause: 64'd8, etval: 64'h5};
        priv      = 2'd3;
        medeleg   = 64'h100;
        stvec     = 64'h4000;
        mtvec     = 64'h9003;
        mstatus   = 64'h1888;
        do_txn("no_deleg_from_m", 1'b0);

        start_cycle();
        except_wb = '{except: 1'b1, epc: 64'h44, ecause: 64'd3, etval: 64'h1};
        mret_wb   = 1'b1;
        mtvec     = 64'hA000;
        mepc      = 64'h1234;
        mstatus   = 64'h888;
        do_txn("trap_over_mret", 1'b0);

        start_cycle();
        mret_wb = 1'b1;
        mstatus = 64'h880;
        mepc    = 64'h1234;
        do_txn("mret", 1'b0);

        start_cycle();
        sret_wb = 1'b1;
        mstatus = 64'h120;
        sepc    = 64'h5678;
        do_txn("sret", 1'b0);

        start_cycle();
        mret_wb = 1'b1;
        sret_wb = 1'b1;
        mstatus = 64'h1120;
        mepc    = 64'hBEE0;
        sepc    = 64'hCAF0;
        do_txn("mret_over_sret", 1'b0);

        start_cycle();
        except_wb = '{except: 1'b1, epc: 64'h10, ecause: 64'h8000_0000_0000_0005, etval: 64'h0};
        medeleg   = '1;
        stvec     = 64'h4000;
        mtvec     = 64'h6000;
        do_txn("interrupt_to_m", 1'b0);

        // Reset lands while the cause write is on the port.
        start_cycle();
        except_wb = '{except: 1'b1, epc: 64'h8000_0010, ecause: 64'd2, etval: 64'hDEAD};
        mtvec     = 64'h8000_0100;
        @(negedge clk);
        @(posedge clk);
        #1;
        valid_wb = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_obs("reset_mid_outputs", '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_obs("reset_mid_quiet", '0);
        end

        for (int n = 0; n < 40; n++) begin
            start_cycle();
            p = int'($urandom_range(0, 3));
            except_wb.except = (p < 2);
            except_wb.epc    = {$urandom, $urandom};
            except_wb.ecause = $urandom_range(0, 1) ? {1'b1, 31'($urandom), $urandom}
                                                    : 64'($urandom_range(0, 15));
            except_wb.etval  = {$urandom, $urandom};
            mret_wb          = (p == 2) || (p < 2 && $urandom_range(0, 1) == 1);
            sret_wb          = (p == 3) || ($urandom_range(0, 1) == 1);
            priv             = ($urandom_range(0, 2) == 2) ? 2'd3 : 2'($urandom_range(0, 1));
            mstatus          = {$urandom, $urandom};
            medeleg          = {$urandom, $urandom};
            mtvec            = {$urandom, $urandom};
            stvec            = {$urandom, $urandom};
            mepc             = {$urandom, $urandom};
            sepc             = {$urandom, $urandom};
            do_txn("random", 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
